// File: rtl/bus_requester.sv
// Initiator side of the four-phase REQ/ACK bus handshake.
// Latches one command, raises REQ, waits for ACK (or times out), then waits for ACK release.
module bus_requester #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  MCLK_IN,
    input  logic                  RESET_IN,
    input  logic                  START_IN,
    input  logic                  RW_IN,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_WIDTH-1:0] WDATA_IN,
    input  logic                  ACK_IN,
    input  logic [DATA_WIDTH-1:0] RDATA_IN,
    output logic                  REQ,
    output logic                  RW,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  BERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RELEASE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  berr_q, berr_d;
    logic                  err_q, err_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        berr_d  = 1'b0;
        err_d   = err_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // A START that collides with a still-high ACK is dropped, not queued.
                if (START_IN && !ACK_IN) begin
                    rw_d    = RW_IN;
                    addr_d  = ADDR_IN;
                    wdata_d = WDATA_IN;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (ACK_IN) begin
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                    if (rw_q) rdata_d = RDATA_IN;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!ACK_IN) begin
                    busy_d  = 1'b0;
                    done_d  = !err_q;
                    berr_d  = err_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            berr_q  <= 1'b0;
            err_q   <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            berr_q  <= berr_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign REQ   = req_q;
    assign RW    = rw_q;
    assign ADDR  = addr_q;
    assign WDATA = wdata_q;
    assign RDATA = rdata_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign BERR  = berr_q;

endmodule

// File: doc/bus_requester.md
Name: bus_requester

Overview:
- Initiator end of the REQ/ACK bus handshake; the DTACK/stepper logic is the responder.
- Accepts one transaction command from a local master (debug loader / DMA path) and drives REQ, address, data and direction.
- Waits for ACK, completes a four-phase handshake and reports completion or a bus-error timeout.
- Sits between the local command source and the 68000-side bus fabric; it must tolerate indefinitely stretched ACK while single-stepping.

Parameters:
- ADDR_WIDTH, 24, width of ADDR_IN/ADDR.
- DATA_WIDTH, 16, width of the write and read data paths.
- TIMEOUT_CYCLES, 1024, number of REQ-asserted cycles without ACK before bus error; 0 disables the timeout (required for stepper mode).

Ports:
- MCLK_IN  in  1  system clock; all logic on the rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- START_IN  in  1  one-cycle command strobe.
- RW_IN  in  1  command direction: 1 = read, 0 = write.
- ADDR_IN  in  ADDR_WIDTH  command address.
- WDATA_IN  in  DATA_WIDTH  command write data.
- ACK_IN  in  1  responder acknowledge; same clock domain.
- RDATA_IN  in  DATA_WIDTH  responder read data, valid while ACK_IN=1.
- REQ  out  1  bus request.
- RW  out  1  latched direction.
- ADDR  out  ADDR_WIDTH  latched address.
- WDATA  out  DATA_WIDTH  latched write data.
- RDATA  out  DATA_WIDTH  captured read data.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse: successful completion.
- BERR  out  1  one-cycle pulse: timeout completion.

Behaviour:
- Reset: state IDLE, timeout counter 0. REQ=0, BUSY=0, DONE=0, BERR=0, RW=1; ADDR, WDATA and RDATA are all-zero. Reset overrides everything, including mid-transaction: REQ falls at that edge and no DONE/BERR is issued.
- DONE and BERR default to 0 every cycle unless set as below. They are never both 1.
- State machine: IDLE, REQUEST, RELEASE.
- IDLE:
  - Accept a command when START_IN=1 and ACK_IN=0.
  - On accept: latch RW_IN/ADDR_IN/WDATA_IN, set REQ=1 and BUSY=1, clear the counter, go to REQUEST.
  - START_IN while ACK_IN=1 is ignored, not queued.
- REQUEST:
  - ADDR/RW/WDATA stay stable.
  - If ACK_IN=1: REQ<=0; if RW=1, RDATA<=RDATA_IN (otherwise RDATA holds); clear the error flag; go to RELEASE.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: REQ<=0, set the error flag, go to RELEASE.
  - Else counter+1.
  - ACK and timeout in the same cycle: ACK wins, normal completion.
- RELEASE:
  - REQ=0; wait for ACK_IN=0. There is no timeout here; ACK held high holds the state.
  - When ACK_IN=0: BUSY<=0, and DONE<=1 (flag clear) or BERR<=1 (flag set); go to IDLE.
- START_IN while BUSY=1 is ignored.
- Latency: the START edge makes REQ visible the next cycle. With zero-wait ACK (ACK high the cycle after REQ, low one cycle after REQ falls), DONE is high 3 cycles after the START edge.
- Timeout: REQ stays high for exactly TIMEOUT_CYCLES cycles.
- Counter width: clog2(TIMEOUT_CYCLES)+1; no wrap in the enabled case. When disabled, the counter does not advance.
- Outputs are registered; there is no combinational path from ACK_IN to REQ.

Test Plan:
- Zero-wait read: ADDR_IN=24'h00_1000, RW_IN=1, RDATA_IN=16'hBEEF, ACK answers 1 cycle after REQ → REQ high 1 cycle, RDATA=16'hBEEF, DONE pulse 3 cycles after START, BERR stays 0.
- Stepped write: WDATA_IN=16'h1234, ACK delayed 5 cycles, then held 4 extra cycles after REQ falls → WDATA/ADDR stable during REQ, REQ low during the hold, DONE only after ACK drops, RDATA unchanged.
- Timeout: TIMEOUT_CYCLES=8, ACK never asserted → REQ high exactly 8 cycles, BERR pulse 1 cycle after REQ falls, DONE=0, BUSY=0 afterwards.
- Coincident ACK/timeout: TIMEOUT_CYCLES=8, ACK first seen in the 8th REQ cycle → DONE=1, BERR=0.
- START ignored: START_IN pulses while BUSY=1 and while in IDLE with ACK_IN=1 → no new REQ and latched ADDR unchanged. Also with TIMEOUT_CYCLES=0, ACK withheld 5000 cycles → REQ still high and no BERR.
- Reset mid-REQUEST: RESET_IN at cycle 3 of REQUEST → next cycle REQ=0, BUSY=0, no DONE/BERR; a fresh START afterwards completes normally.
